// File: rtl/counter_driver_pkg.sv
// counter_driver_pkg
//   Shared definitions for the counter command driver:
//   - default data / step widths
//   - command opcode encoding
//   - FSM state encoding
//   - small constant helper used to size the command argument bus
package counter_driver_pkg;

    // Default widths for the counter data path and the step-count argument.
    localparam int DEF_WIDTH  = 8;
    localparam int DEF_STEP_W = 8;

    // Command opcodes carried on cmd_op_in.
    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_UP   = 2'b01;
    localparam logic [1:0] OP_DOWN = 2'b10;
    localparam logic [1:0] OP_RSVD = 2'b11;

    // Driver sequencing states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_RUN    = 3'd2,
        ST_SETTLE = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // Larger of two integers; used to size the shared argument bus.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/step_counter.sv
// step_counter
//   Loadable down-counter that measures the length of the RUN phase.
//   The count is loaded with the requested number of steps when a command
//   is accepted and decremented once per RUN cycle. 'last' is high while
//   the count equals one, i.e. during the final RUN cycle.
//
// Ports:
//   clk       clock, rising edge
//   rst       asynchronous active-high reset
//   load      load load_val (has priority over dec)
//   load_val  step count to load
//   dec       decrement by one
//   last      count == 1
module step_counter #(
    parameter int STEP_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [STEP_W-1:0] load_val,
    input  logic              dec,
    output logic              last
);

    localparam logic [STEP_W-1:0] ONE = STEP_W'(1);

    logic [STEP_W-1:0] count_reg;
    logic [STEP_W-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (load) begin
            count_next = load_val;
        end else if (dec) begin
            count_next = count_reg - ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign last = (count_reg == ONE);

endmodule

// File: rtl/counter_driver.sv
// counter_driver
//   Command-driven master for an up/down counter. Accepts LOAD, COUNT_UP
//   and COUNT_DOWN commands over a valid/ready handshake, sequences the
//   counter control pins cycle-accurately, then reports the resulting
//   count and whether the counter flagged an overflow along the way.
//
//   Sequence after the accept edge (cycle T = accept cycle):
//     LOAD       : set in T+1, settle T+2, done T+3
//     UP/DOWN N  : en in T+1..T+N, settle T+N+1, done T+N+2
//     UP/DOWN 0  : settle T+1, done T+2
//     reserved   : done + err in T+1
//
// Ports:
//   clk_in, rst_in     clock (rising edge) / asynchronous active-high reset
//   cmd_valid_in       command present
//   cmd_ready_out      block idle and able to accept
//   cmd_op_in          opcode (LOAD / UP / DOWN / reserved)
//   cmd_arg_in         load value (low WIDTH bits) or step count (low STEP_W bits)
//   en_ctrl_out        counter enable
//   set_ctrl_out       counter synchronous load
//   up_ctrl_out        counter direction, 1 = up
//   counter_val_out    counter load value (last LOAD value)
//   cnt_q_in           counter current value
//   cnt_ovf_in         counter overflow flag
//   done_out           one-cycle completion pulse
//   result_out         count sampled at completion, held
//   ovf_seen_out       overflow seen during last command, held
//   err_out            one-cycle pulse with done_out for reserved opcode
module counter_driver
    import counter_driver_pkg::*;
#(
    parameter int  WIDTH  = DEF_WIDTH,
    parameter int  STEP_W = DEF_STEP_W,
    localparam int ARG_W  = max_int(WIDTH, STEP_W)
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             cmd_valid_in,
    output logic             cmd_ready_out,
    input  logic [1:0]       cmd_op_in,
    input  logic [ARG_W-1:0] cmd_arg_in,
    output logic             en_ctrl_out,
    output logic             set_ctrl_out,
    output logic             up_ctrl_out,
    output logic [WIDTH-1:0] counter_val_out,
    input  logic [WIDTH-1:0] cnt_q_in,
    input  logic             cnt_ovf_in,
    output logic             done_out,
    output logic [WIDTH-1:0] result_out,
    output logic             ovf_seen_out,
    output logic             err_out
);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t            state_reg;
    state_t            state_next;
    logic [1:0]        op_reg;
    logic [1:0]        op_next;
    logic              first_run_reg;
    logic              first_run_next;
    logic              ovf_acc_reg;
    logic              ovf_acc_next;

    // Output registers
    logic              ready_reg,     ready_next;
    logic              en_reg,        en_next;
    logic              set_reg,       set_next;
    logic              up_reg,        up_next;
    logic [WIDTH-1:0]  val_reg,       val_next;
    logic              done_reg,      done_next;
    logic [WIDTH-1:0]  result_reg,    result_next;
    logic              ovf_seen_reg,  ovf_seen_next;
    logic              err_reg,       err_next;

    // ------------------------------------------------------------------
    // Handshake and argument decode
    // ------------------------------------------------------------------
    logic              accept;
    logic [STEP_W-1:0] steps_arg;
    logic              steps_zero;
    logic [1:0]        eff_op;
    logic              step_last;

    // ready is registered and only high in IDLE, so accept implies IDLE.
    assign accept     = cmd_valid_in & ready_reg;
    assign steps_arg  = cmd_arg_in[STEP_W-1:0];
    assign steps_zero = (steps_arg == '0);

    // Outputs are registered from the next state, so on the accept edge the
    // opcode has not reached op_reg yet; take it from the bus in that case.
    assign eff_op = accept ? cmd_op_in : op_reg;

    // RUN length counter: loaded on every accept, only consulted in RUN.
    step_counter #(
        .STEP_W (STEP_W)
    ) u_step_counter (
        .clk      (clk_in),
        .rst      (rst_in),
        .load     (accept),
        .load_val (steps_arg),
        .dec      (state_reg == ST_RUN),
        .last     (step_last)
    );

    // ------------------------------------------------------------------
    // FSM process 1: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM process 2: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    case (cmd_op_in)
                        OP_LOAD: state_next = ST_LOAD;
                        OP_UP,
                        OP_DOWN: state_next = steps_zero ? ST_SETTLE : ST_RUN;
                        default: state_next = ST_DONE;
                    endcase
                end
            end
            ST_LOAD:   state_next = ST_SETTLE;
            ST_RUN:    state_next = step_last ? ST_SETTLE : ST_RUN;
            ST_SETTLE: state_next = ST_DONE;
            ST_DONE:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM process 3: output / datapath next values
    // Every output is decoded from state_next and registered, so a pin
    // is high exactly during the cycles spent in the matching state.
    // ------------------------------------------------------------------
    always_comb begin
        ready_next     = (state_next == ST_IDLE);
        en_next        = (state_next == ST_RUN);
        set_next       = (state_next == ST_LOAD);
        up_next        = (state_next == ST_RUN) && (eff_op == OP_UP);
        done_next      = (state_next == ST_DONE);
        err_next       = (state_next == ST_DONE) && (eff_op == OP_RSVD);

        op_next        = accept ? cmd_op_in : op_reg;

        // The load value stays on the pins until the next LOAD command.
        val_next       = val_reg;
        if (accept && (cmd_op_in == OP_LOAD)) begin
            val_next = cmd_arg_in[WIDTH-1:0];
        end

        // The first RUN cycle still shows the counter's flag from before
        // the command started, so it is excluded from the overflow OR.
        first_run_next = first_run_reg;
        if (accept) begin
            first_run_next = 1'b1;
        end else if (state_reg == ST_RUN) begin
            first_run_next = 1'b0;
        end

        ovf_acc_next   = ovf_acc_reg;
        if (accept) begin
            ovf_acc_next = 1'b0;
        end else if ((state_reg == ST_RUN) && !first_run_reg) begin
            ovf_acc_next = ovf_acc_reg | cnt_ovf_in;
        end else if (state_reg == ST_SETTLE) begin
            ovf_acc_next = ovf_acc_reg | cnt_ovf_in;
        end

        // Count is captured at the end of SETTLE so it appears in DONE.
        // A reserved op skips SETTLE, leaving the previous result intact.
        result_next    = result_reg;
        if (state_reg == ST_SETTLE) begin
            result_next = cnt_q_in;
        end

        ovf_seen_next  = ovf_seen_reg;
        if (state_next == ST_DONE) begin
            ovf_seen_next = ovf_acc_next;
        end
    end

    // ------------------------------------------------------------------
    // Output and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            ready_reg     <= 1'b0;
            en_reg        <= 1'b0;
            set_reg       <= 1'b0;
            up_reg        <= 1'b0;
            val_reg       <= '0;
            done_reg      <= 1'b0;
            result_reg    <= '0;
            ovf_seen_reg  <= 1'b0;
            err_reg       <= 1'b0;
            op_reg        <= OP_LOAD;
            first_run_reg <= 1'b0;
            ovf_acc_reg   <= 1'b0;
        end else begin
            ready_reg     <= ready_next;
            en_reg        <= en_next;
            set_reg       <= set_next;
            up_reg        <= up_next;
            val_reg       <= val_next;
            done_reg      <= done_next;
            result_reg    <= result_next;
            ovf_seen_reg  <= ovf_seen_next;
            err_reg       <= err_next;
            op_reg        <= op_next;
            first_run_reg <= first_run_next;
            ovf_acc_reg   <= ovf_acc_next;
        end
    end

    assign cmd_ready_out   = ready_reg;
    assign en_ctrl_out     = en_reg;
    assign set_ctrl_out    = set_reg;
    assign up_ctrl_out     = up_reg;
    assign counter_val_out = val_reg;
    assign done_out        = done_reg;
    assign result_out      = result_reg;
    assign ovf_seen_out    = ovf_seen_reg;
    assign err_out         = err_reg;

endmodule

// File: tb/tb_counter_driver.sv
// tb_counter_driver
//   Directed bench for counter_driver with a behavioural up/down counter
//   attached. Stimulus pushes hand-computed expectations into a queue on
//   each accept; an independent monitor pops and compares on done_out.
module tb_counter_driver;

    localparam int WIDTH  = 8;
    localparam int STEP_W = 8;
    localparam int ARG_W  = 8;

    logic             clk_in = 1'b0;
    logic             rst_in = 1'b1;
    logic             cmd_valid_in = 1'b0;
    logic             cmd_ready_out;
    logic [1:0]       cmd_op_in = 2'b00;
    logic [ARG_W-1:0] cmd_arg_in = '0;
    logic             en_ctrl_out;
    logic             set_ctrl_out;
    logic             up_ctrl_out;
    logic [WIDTH-1:0] counter_val_out;
    logic [WIDTH-1:0] cnt_q;
    logic             cnt_ovf;
    logic             done_out;
    logic [WIDTH-1:0] result_out;
    logic             ovf_seen_out;
    logic             err_out;

    logic             cnt_rst = 1'b1;
    int               cyc = 0;
    int               total = 0;
    int               bad = 0;
    int               txn = 0;

    typedef struct {
        logic [7:0] result;
        logic       ovf;
        logic       chk_ovf;
        logic       err;
        int         en_n;
        int         set_n;
        logic       up;
        logic [7:0] val;
        int         done_cyc;
    } exp_t;

    exp_t exp_q[$];

    counter_driver #(
        .WIDTH  (WIDTH),
        .STEP_W (STEP_W)
    ) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .cmd_valid_in    (cmd_valid_in),
        .cmd_ready_out   (cmd_ready_out),
        .cmd_op_in       (cmd_op_in),
        .cmd_arg_in      (cmd_arg_in),
        .en_ctrl_out     (en_ctrl_out),
        .set_ctrl_out    (set_ctrl_out),
        .up_ctrl_out     (up_ctrl_out),
        .counter_val_out (counter_val_out),
        .cnt_q_in        (cnt_q),
        .cnt_ovf_in      (cnt_ovf),
        .done_out        (done_out),
        .result_out      (result_out),
        .ovf_seen_out    (ovf_seen_out),
        .err_out         (err_out)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    // Counter peripheral: sync load, enable, direction; overflow pulses for
    // one cycle after a wrap in either direction. Only its own reset clears it.
    always @(posedge clk_in) begin
        if (cnt_rst) begin
            cnt_q   <= 8'h00;
            cnt_ovf <= 1'b0;
        end else if (set_ctrl_out) begin
            cnt_q   <= counter_val_out;
            cnt_ovf <= 1'b0;
        end else if (en_ctrl_out) begin
            if (up_ctrl_out) begin
                cnt_q   <= cnt_q + 8'h01;
                cnt_ovf <= (cnt_q == 8'hFF);
            end else begin
                cnt_q   <= cnt_q - 8'h01;
                cnt_ovf <= (cnt_q == 8'h00);
            end
        end else begin
            cnt_ovf <= 1'b0;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------
    initial begin
        int   en_seen;
        int   set_seen;
        exp_t e;
        en_seen  = 0;
        set_seen = 0;
        forever begin
            @(negedge clk_in);
            if (rst_in) begin
                en_seen  = 0;
                set_seen = 0;
            end else begin
                if (en_ctrl_out)  en_seen++;
                if (set_ctrl_out) set_seen++;
                if (en_ctrl_out && set_ctrl_out) check("en_set_overlap", 1, 0);
                if (en_ctrl_out && exp_q.size() > 0) check("up_dir", up_ctrl_out, exp_q[0].up);
                if (done_out) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_done", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        txn++;
                        $display("txn %0d: cycle=%0d result=%02h ovf=%0b err=%0b en_cycles=%0d set_cycles=%0d",
                                 txn, cyc, result_out, ovf_seen_out, err_out, en_seen, set_seen);
                        check("done_cycle", cyc, e.done_cyc);
                        check("result", result_out, e.result);
                        check("err", err_out, e.err);
                        if (e.chk_ovf) check("ovf_seen", ovf_seen_out, e.ovf);
                        check("en_cycles", en_seen, e.en_n);
                        check("set_cycles", set_seen, e.set_n);
                        check("counter_val", counter_val_out, e.val);
                    end
                    en_seen  = 0;
                    set_seen = 0;
                end else if (err_out) begin
                    check("err_without_done", 1, 0);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus: one command per call; called and returns at a negedge.
    // ------------------------------------------------------------------
    task automatic issue(input logic [1:0] op, input logic [7:0] arg,
                         input logic [7:0] res, input logic ovf, input logic chk_ovf,
                         input logic err, input int en_n, input int set_n,
                         input logic up, input logic [7:0] val, input int lat,
                         input bit push);
        int   waited;
        exp_t e;
        waited = 0;
        while (!cmd_ready_out && waited < 1000) begin
            @(negedge clk_in);
            waited++;
        end
        if (!cmd_ready_out) begin
            check("ready_timeout", 0, 1);
            return;
        end
        cmd_valid_in = 1'b1;
        cmd_op_in    = op;
        cmd_arg_in   = arg;
        @(posedge clk_in);
        #1;
        if (push) begin
            e.result   = res;
            e.ovf      = ovf;
            e.chk_ovf  = chk_ovf;
            e.err      = err;
            e.en_n     = en_n;
            e.set_n    = set_n;
            e.up       = up;
            e.val      = val;
            e.done_cyc = cyc + lat - 1;
            exp_q.push_back(e);
        end
        cmd_valid_in = 1'b0;
        @(negedge clk_in);
    endtask

    initial begin
        int waited;

        // Reset state
        repeat (3) @(negedge clk_in);
        check("rst_ready", cmd_ready_out, 0);
        check("rst_en", en_ctrl_out, 0);
        check("rst_set", set_ctrl_out, 0);
        check("rst_done", done_out, 0);
        check("rst_val", counter_val_out, 0);
        check("rst_result", result_out, 0);
        rst_in  = 1'b0;
        cnt_rst = 1'b0;
        @(negedge clk_in);
        check("ready_after_rst", cmd_ready_out, 1);

        //     op     arg    res    ovf  chk  err  en   set up   val    lat
        issue(2'b00, 8'hA5, 8'hA5, 1'b0, 1'b1, 1'b0, 0,   1, 1'b0, 8'hA5, 3,   1'b1);
        issue(2'b00, 8'hFD, 8'hFD, 1'b0, 1'b1, 1'b0, 0,   1, 1'b0, 8'hFD, 3,   1'b1);
        issue(2'b01, 8'd3,  8'h00, 1'b1, 1'b1, 1'b0, 3,   0, 1'b1, 8'hFD, 5,   1'b1);
        issue(2'b00, 8'h01, 8'h01, 1'b0, 1'b1, 1'b0, 0,   1, 1'b0, 8'h01, 3,   1'b1);
        issue(2'b10, 8'd2,  8'hFF, 1'b1, 1'b1, 1'b0, 2,   0, 1'b0, 8'h01, 4,   1'b1);
        issue(2'b01, 8'd0,  8'hFF, 1'b0, 1'b1, 1'b0, 0,   0, 1'b1, 8'h01, 2,   1'b1);
        issue(2'b11, 8'h55, 8'hFF, 1'b0, 1'b0, 1'b1, 0,   0, 1'b0, 8'h01, 1,   1'b1);
        issue(2'b01, 8'd5,  8'h04, 1'b1, 1'b1, 1'b0, 5,   0, 1'b1, 8'h01, 7,   1'b1);
        issue(2'b10, 8'd1,  8'h03, 1'b0, 1'b1, 1'b0, 1,   0, 1'b0, 8'h01, 3,   1'b1);
        issue(2'b01, 8'd255,8'h02, 1'b1, 1'b1, 1'b0, 255, 0, 1'b1, 8'h01, 257, 1'b1);

        // Abort a long COUNT_UP with reset partway through RUN
        issue(2'b00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 0,   1, 1'b0, 8'h00, 3,   1'b1);
        issue(2'b01, 8'd10, 8'h00, 1'b0, 1'b0, 1'b0, 10,  0, 1'b1, 8'h00, 12,  1'b0);
        repeat (3) @(negedge clk_in);
        check("midrun_en", en_ctrl_out, 1);
        #2 rst_in = 1'b1;
        #1;
        check("abort_en", en_ctrl_out, 0);
        check("abort_up", up_ctrl_out, 0);
        check("abort_set", set_ctrl_out, 0);
        check("abort_done", done_out, 0);
        check("abort_ready", cmd_ready_out, 0);
        exp_q.delete();
        repeat (2) @(negedge clk_in);
        rst_in = 1'b0;
        @(negedge clk_in);
        check("ready_after_abort", cmd_ready_out, 1);
        check("val_after_abort", counter_val_out, 0);

        // Reserved op: result must stay at its reset value although the
        // counter has moved away from zero.
        issue(2'b11, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 0,   0, 1'b0, 8'h00, 1,   1'b1);
        issue(2'b00, 8'h3C, 8'h3C, 1'b0, 1'b1, 1'b0, 0,   1, 1'b0, 8'h3C, 3,   1'b1);

        waited = 0;
        while (exp_q.size() > 0 && waited < 2000) begin
            @(negedge clk_in);
            waited++;
        end
        check("drain_timeout", exp_q.size(), 0);
        repeat (2) @(negedge clk_in);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
